io_port_responder: RTL and testbench
====================================

Name: io_port_responder

Overview:
- External-side responder for the processor's 16-bit IO interface: the far end of the IN/OUT port pair.
- OUT instructions push cpu_out_data into a TX FIFO that drains to an external device over a valid/ready handshake.
- External words arrive over valid/ready into an RX FIFO whose head is presented on cpu_in_data; IN instructions pop it.
- Sits between the processor top level (portIn/portOut plus the IOR/IOW strobes from the memory stage) and board-level peripherals.

Parameters:
DATA_W, 16, port data width
TX_DEPTH, 4, TX FIFO entries; power of two, at least 2
RX_DEPTH, 4, RX FIFO entries; power of two, at least 2

Ports:
clk  in  1  single clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
cpu_out_data  in  DATA_W  processor portOut value
cpu_out_we  in  1  one-cycle IOW strobe (OUT executed)
cpu_in_data  out  DATA_W  processor portIn value
cpu_in_re  in  1  one-cycle IOR strobe (IN consumed)
cpu_in_valid  out  1  RX FIFO non-empty
ext_tx_data  out  DATA_W  word offered to external device
ext_tx_valid  out  1  TX FIFO non-empty
ext_tx_ready  in  1  external device accepts word
ext_rx_data  in  DATA_W  word from external device
ext_rx_valid  in  1  external word offered
ext_rx_ready  out  1  RX FIFO not full
tx_full  out  1  TX FIFO full
err_clr  in  1  clears sticky error flags
tx_overflow  out  1  sticky: OUT dropped because TX FIFO full
rx_underrun  out  1  sticky: IN issued while RX FIFO empty

Behaviour:
- Reset (reset=0, asynchronous):
  - Both FIFOs empty; pointers and counts at 0.
  - cpu_in_data=0, last-read register=0.
  - ext_tx_valid=0, cpu_in_valid=0, ext_rx_ready=1, tx_full=0, tx_overflow=0, rx_underrun=0.
  - ext_tx_data is don't-care but driven to 0.
  - Reset mid-transfer discards all stored words with no handshake completion.
- TX path:
  - Push when cpu_out_we=1 and (count<TX_DEPTH or a pop happens in the same cycle).
  - The word appears on ext_tx_data with ext_tx_valid=1 on the next cycle (first-word-fall-through).
  - Pop when ext_tx_valid and ext_tx_ready are both 1.
  - ext_tx_data must stay stable while valid=1 and ready=0.
  - Simultaneous push and pop at any count: count unchanged, order preserved.
  - Push while full with no pop: word dropped, tx_overflow set the next cycle.
- RX path:
  - ext_rx_ready = (rx_count<RX_DEPTH); it does not depend on cpu_in_re, so there is no combinational path.
  - Push on ext_rx_valid and ext_rx_ready.
  - cpu_in_data = RX head when non-empty, else the last-read register.
  - Pop on cpu_in_re while non-empty; the popped value is loaded into the last-read register.
  - cpu_in_re while empty: no pop, cpu_in_data holds the last-read value, rx_underrun set the next cycle.
  - Push into an empty FIFO becomes visible on cpu_in_data and cpu_in_valid the next cycle.
- Pointers:
  - Width clog2(DEPTH), wrapping modulo DEPTH.
  - Count width clog2(DEPTH)+1.
  - Full and empty are derived from count, never from pointer equality alone.
- Error flags:
  - Sticky until err_clr=1.
  - err_clr in the same cycle as a new error event: the set wins.
- All outputs except cpu_in_data and ext_tx_data come straight from registers or register comparisons.

Decomposition:
- Shared package io_pkg:
  - IO_DATA_W=16.
  - Default depths.
  - Pointer-width function.
- Sub-module io_sync_fifo (params WIDTH, DEPTH):
  - Ports: push, pop, din, dout (FWFT), count, full, empty.
  - Same clk and active-low asynchronous reset.
  - Instantiated once for TX and once for RX.
- The top level holds the handshake glue, the last-read register and the error flags.

Test Plan:
1. Reset then idle → ext_tx_valid=0, cpu_in_valid=0, ext_rx_ready=1, cpu_in_data=0x0000, both error flags 0.
2. OUT 0x1234, 0x5678 on consecutive cycles with ext_tx_ready=0 → ext_tx_valid=1 and ext_tx_data=0x1234 held stable. Raise ready for 2 cycles → 0x1234 then 0x5678 transferred, then valid=0.
3. 5 OUT strobes (0xA000..0xA004) with ready=0, TX_DEPTH=4 → tx_full=1 after the 4th. 5th dropped, tx_overflow=1. Drain yields only A000..A003. err_clr → tx_overflow=0.
4. TX full and ext_tx_ready=1, OUT 0xBEEF the same cycle → accepted, tx_full stays 1, no overflow. 0xBEEF is emitted 4th after the current head.
5. External pushes 0x0011, 0x0022, then cpu_in_re twice → cpu_in_data shows 0x0011 then 0x0022. Third cpu_in_re → cpu_in_data stays 0x0022, rx_underrun=1.
6. Fill RX with 4 words → ext_rx_ready=0 and ext_rx_valid held with 0x0099 is not accepted. One cpu_in_re → ext_rx_ready=1 the next cycle and 0x0099 is accepted. Assert reset mid-stream → all FIFOs empty and flags cleared immediately.

Source files
------------

// File: rtl/io_pkg.sv
// Shared widths, default depths and pointer sizing for the IO port responder.
// No logic; no latency or backpressure of its own.
package io_pkg;

  localparam int IO_DATA_W   = 16;
  localparam int IO_TX_DEPTH = 4;
  localparam int IO_RX_DEPTH = 4;

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FWFT FIFO: a pushed word is on dout the cycle after the push.
// Push is refused when full unless a pop lands in the same cycle; pop is ignored when empty.
import io_pkg::*;

module io_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PW = ptr_w(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Forced to zero when empty so stale storage never leaks onto the bus.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_port_responder.sv
// Far end of the CPU IN/OUT port pair: OUT words to the TX FIFO, external words via the RX FIFO to IN; FWFT, one-cycle latency.
// Backpressure: ext_rx_ready drops when RX is full; OUT while TX is full is dropped and flagged, IN while RX is empty is flagged.
import io_pkg::*;

module io_port_responder #(
  parameter int DATA_W   = IO_DATA_W,
  parameter int TX_DEPTH = IO_TX_DEPTH,
  parameter int RX_DEPTH = IO_RX_DEPTH,
  localparam int TX_CW = ptr_w(TX_DEPTH) + 1,
  localparam int RX_CW = ptr_w(RX_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] cpu_out_data,
  input  logic              cpu_out_we,
  output logic [DATA_W-1:0] cpu_in_data,
  input  logic              cpu_in_re,
  output logic              cpu_in_valid,
  output logic [DATA_W-1:0] ext_tx_data,
  output logic              ext_tx_valid,
  input  logic              ext_tx_ready,
  input  logic [DATA_W-1:0] ext_rx_data,
  input  logic              ext_rx_valid,
  output logic              ext_rx_ready,
  output logic              tx_full,
  input  logic              err_clr,
  output logic              tx_overflow,
  output logic              rx_underrun
);

  logic [TX_CW-1:0]  tx_count;
  logic              tx_empty;
  logic              tx_pop;
  logic [RX_CW-1:0]  rx_count;
  logic              rx_empty;
  logic              rx_full;
  logic              rx_push;
  logic              rx_pop;
  logic [DATA_W-1:0] rx_head;
  logic [DATA_W-1:0] last_rd;
  logic              tx_drop;
  logic              rx_starve;

  assign ext_tx_valid = !tx_empty;
  assign tx_pop       = ext_tx_valid && ext_tx_ready;

  io_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (cpu_out_we),
    .pop   (tx_pop),
    .din   (cpu_out_data),
    .dout  (ext_tx_data),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Ready is a pure function of stored occupancy, so it never depends on cpu_in_re.
  assign ext_rx_ready = !rx_full;
  assign rx_push      = ext_rx_valid && ext_rx_ready;
  assign cpu_in_valid = !rx_empty;
  assign rx_pop       = cpu_in_re && !rx_empty;

  io_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (ext_rx_data),
    .dout  (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // With RX drained, the CPU keeps seeing the last word it consumed.
  assign cpu_in_data = rx_empty ? last_rd : rx_head;

  assign tx_drop   = cpu_out_we && (tx_count == TX_CW'(TX_DEPTH)) && !tx_pop;
  assign rx_starve = cpu_in_re && (rx_count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_rd     <= '0;
      tx_overflow <= 1'b0;
      rx_underrun <= 1'b0;
    end else begin
      if (rx_pop) begin
        last_rd <= rx_head;
      end
      // A fresh error event outranks a clear in the same cycle.
      tx_overflow <= tx_drop   || (tx_overflow && !err_clr);
      rx_underrun <= rx_starve || (rx_underrun && !err_clr);
    end
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder: TX/RX FWFT ordering, full/empty boundaries, sticky flags, async reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_io_port_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cpu_out_data = '0;
  logic        cpu_out_we = 1'b0;
  logic [15:0] cpu_in_data;
  logic        cpu_in_re = 1'b0;
  logic        cpu_in_valid;
  logic [15:0] ext_tx_data;
  logic        ext_tx_valid;
  logic        ext_tx_ready = 1'b0;
  logic [15:0] ext_rx_data = '0;
  logic        ext_rx_valid = 1'b0;
  logic        ext_rx_ready;
  logic        tx_full;
  logic        err_clr = 1'b0;
  logic        tx_overflow;
  logic        rx_underrun;

  int tests_run = 0;
  int fails = 0;

  io_port_responder dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_out_data (cpu_out_data),
    .cpu_out_we   (cpu_out_we),
    .cpu_in_data  (cpu_in_data),
    .cpu_in_re    (cpu_in_re),
    .cpu_in_valid (cpu_in_valid),
    .ext_tx_data  (ext_tx_data),
    .ext_tx_valid (ext_tx_valid),
    .ext_tx_ready (ext_tx_ready),
    .ext_rx_data  (ext_rx_data),
    .ext_rx_valid (ext_rx_valid),
    .ext_rx_ready (ext_rx_ready),
    .tx_full      (tx_full),
    .err_clr      (err_clr),
    .tx_overflow  (tx_overflow),
    .rx_underrun  (rx_underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    tests_run++;
    if ({ext_tx_valid, cpu_in_valid, ext_rx_ready, tx_full} !== 4'b0010) begin
      fails++;
      $display("FAIL reset_handshake: got %b want 0010", {ext_tx_valid, cpu_in_valid, ext_rx_ready, tx_full});
    end
    tests_run++;
    if (cpu_in_data !== 16'h0000 || ext_tx_data !== 16'h0000) begin
      fails++;
      $display("FAIL reset_data: in=%h tx=%h want 0000/0000", cpu_in_data, ext_tx_data);
    end
    tests_run++;
    if ({tx_overflow, rx_underrun} !== 2'b00) begin
      fails++;
      $display("FAIL reset_flags: got %b want 00", {tx_overflow, rx_underrun});
    end
  endtask

  task automatic test_tx_basic();
    logic [15:0] exp [2];
    exp[0] = 16'h1234;
    exp[1] = 16'h5678;
    cpu_out_we = 1'b1;
    cpu_out_data = 16'h1234;
    step();
    tests_run++;
    if (ext_tx_valid !== 1'b1 || ext_tx_data !== 16'h1234) begin
      fails++;
      $display("FAIL tx_first_word: valid=%b data=%h want 1/1234", ext_tx_valid, ext_tx_data);
    end
    cpu_out_data = 16'h5678;
    step();
    cpu_out_we = 1'b0;
    step();
    tests_run++;
    if (ext_tx_valid !== 1'b1 || ext_tx_data !== 16'h1234) begin
      fails++;
      $display("FAIL tx_hold_stable: valid=%b data=%h want 1/1234", ext_tx_valid, ext_tx_data);
    end
    ext_tx_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (ext_tx_valid !== 1'b1 || ext_tx_data !== exp[i]) begin
        fails++;
        $display("FAIL tx_transfer_%0d: valid=%b data=%h want 1/%h", i, ext_tx_valid, ext_tx_data, exp[i]);
      end
      step();
    end
    ext_tx_ready = 1'b0;
    tests_run++;
    if (ext_tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL tx_drained: valid=%b want 0", ext_tx_valid);
    end
  endtask

  task automatic test_tx_overflow();
    cpu_out_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cpu_out_data = 16'hA000 + 16'(i);
      step();
      if (i == 3) begin
        tests_run++;
        if (tx_full !== 1'b1 || tx_overflow !== 1'b0) begin
          fails++;
          $display("FAIL tx_full_at_4: full=%b ovf=%b want 1/0", tx_full, tx_overflow);
        end
      end
    end
    cpu_out_we = 1'b0;
    tests_run++;
    if (tx_overflow !== 1'b1) begin
      fails++;
      $display("FAIL tx_overflow_set: got %b want 1", tx_overflow);
    end
    ext_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (ext_tx_valid !== 1'b1 || ext_tx_data !== 16'hA000 + 16'(i)) begin
        fails++;
        $display("FAIL tx_ovf_drain_%0d: valid=%b data=%h want 1/%h", i, ext_tx_valid, ext_tx_data, 16'hA000 + 16'(i));
      end
      step();
    end
    ext_tx_ready = 1'b0;
    tests_run++;
    if (ext_tx_valid !== 1'b0 || tx_full !== 1'b0) begin
      fails++;
      $display("FAIL tx_ovf_empty: valid=%b full=%b want 0/0", ext_tx_valid, tx_full);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    tests_run++;
    if (tx_overflow !== 1'b0) begin
      fails++;
      $display("FAIL tx_overflow_clr: got %b want 0", tx_overflow);
    end
  endtask

  task automatic test_tx_full_push_pop();
    logic [15:0] exp [4];
    exp[0] = 16'hC001;
    exp[1] = 16'hC002;
    exp[2] = 16'hC003;
    exp[3] = 16'hBEEF;
    cpu_out_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_out_data = 16'hC000 + 16'(i);
      step();
    end
    ext_tx_ready = 1'b1;
    cpu_out_data = 16'hBEEF;
    step();
    cpu_out_we = 1'b0;
    tests_run++;
    if (tx_full !== 1'b1 || tx_overflow !== 1'b0) begin
      fails++;
      $display("FAIL tx_full_pushpop: full=%b ovf=%b want 1/0", tx_full, tx_overflow);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (ext_tx_valid !== 1'b1 || ext_tx_data !== exp[i]) begin
        fails++;
        $display("FAIL tx_pushpop_order_%0d: valid=%b data=%h want 1/%h", i, ext_tx_valid, ext_tx_data, exp[i]);
      end
      step();
    end
    ext_tx_ready = 1'b0;
    tests_run++;
    if (ext_tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL tx_pushpop_empty: valid=%b want 0", ext_tx_valid);
    end
  endtask

  task automatic test_rx_basic();
    ext_rx_valid = 1'b1;
    ext_rx_data = 16'h0011;
    step();
    ext_rx_data = 16'h0022;
    step();
    ext_rx_valid = 1'b0;
    tests_run++;
    if (cpu_in_valid !== 1'b1 || cpu_in_data !== 16'h0011) begin
      fails++;
      $display("FAIL rx_head_first: valid=%b data=%h want 1/0011", cpu_in_valid, cpu_in_data);
    end
    cpu_in_re = 1'b1;
    step();
    tests_run++;
    if (cpu_in_valid !== 1'b1 || cpu_in_data !== 16'h0022) begin
      fails++;
      $display("FAIL rx_head_second: valid=%b data=%h want 1/0022", cpu_in_valid, cpu_in_data);
    end
    step();
    tests_run++;
    if (cpu_in_valid !== 1'b0 || cpu_in_data !== 16'h0022 || rx_underrun !== 1'b0) begin
      fails++;
      $display("FAIL rx_last_read: valid=%b data=%h unr=%b want 0/0022/0", cpu_in_valid, cpu_in_data, rx_underrun);
    end
    step();
    cpu_in_re = 1'b0;
    tests_run++;
    if (cpu_in_data !== 16'h0022 || rx_underrun !== 1'b1) begin
      fails++;
      $display("FAIL rx_underrun: data=%h unr=%b want 0022/1", cpu_in_data, rx_underrun);
    end
    cpu_in_re = 1'b1;
    err_clr = 1'b1;
    step();
    cpu_in_re = 1'b0;
    tests_run++;
    if (rx_underrun !== 1'b1) begin
      fails++;
      $display("FAIL rx_set_beats_clr: got %b want 1", rx_underrun);
    end
    step();
    err_clr = 1'b0;
    tests_run++;
    if (rx_underrun !== 1'b0) begin
      fails++;
      $display("FAIL rx_underrun_clr: got %b want 0", rx_underrun);
    end
  endtask

  task automatic test_rx_full_and_reset();
    logic [15:0] exp [4];
    exp[0] = 16'h0002;
    exp[1] = 16'h0003;
    exp[2] = 16'h0004;
    exp[3] = 16'h0099;
    ext_rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ext_rx_data = 16'(i + 1);
      step();
    end
    tests_run++;
    if (ext_rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL rx_full_ready: got %b want 0", ext_rx_ready);
    end
    ext_rx_data = 16'h0099;
    step();
    tests_run++;
    if (ext_rx_ready !== 1'b0 || cpu_in_data !== 16'h0001) begin
      fails++;
      $display("FAIL rx_full_hold: rdy=%b data=%h want 0/0001", ext_rx_ready, cpu_in_data);
    end
    cpu_in_re = 1'b1;
    step();
    cpu_in_re = 1'b0;
    tests_run++;
    if (ext_rx_ready !== 1'b1 || cpu_in_data !== 16'h0002) begin
      fails++;
      $display("FAIL rx_ready_reopen: rdy=%b data=%h want 1/0002", ext_rx_ready, cpu_in_data);
    end
    step();
    ext_rx_valid = 1'b0;
    tests_run++;
    if (ext_rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL rx_refill: rdy=%b want 0", ext_rx_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (cpu_in_valid !== 1'b1 || cpu_in_data !== exp[i]) begin
        fails++;
        $display("FAIL rx_drain_%0d: valid=%b data=%h want 1/%h", i, cpu_in_valid, cpu_in_data, exp[i]);
      end
      cpu_in_re = 1'b1;
      step();
      cpu_in_re = 1'b0;
    end
    cpu_in_re = 1'b1;
    step();
    cpu_in_re = 1'b0;
    cpu_out_we = 1'b1;
    cpu_out_data = 16'h7777;
    step();
    cpu_out_data = 16'h8888;
    step();
    cpu_out_we = 1'b0;
    ext_rx_valid = 1'b1;
    ext_rx_data = 16'h4242;
    step();
    ext_rx_valid = 1'b0;
    tests_run++;
    if (ext_tx_valid !== 1'b1 || cpu_in_valid !== 1'b1 || rx_underrun !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_state: txv=%b inv=%b unr=%b want 1/1/1", ext_tx_valid, cpu_in_valid, rx_underrun);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({ext_tx_valid, cpu_in_valid, ext_rx_ready, tx_full, tx_overflow, rx_underrun} !== 6'b001000) begin
      fails++;
      $display("FAIL async_reset_ctrl: got %b want 001000",
               {ext_tx_valid, cpu_in_valid, ext_rx_ready, tx_full, tx_overflow, rx_underrun});
    end
    tests_run++;
    if (cpu_in_data !== 16'h0000 || ext_tx_data !== 16'h0000) begin
      fails++;
      $display("FAIL async_reset_data: in=%h tx=%h want 0000/0000", cpu_in_data, ext_tx_data);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_overflow();
    test_tx_full_push_pop();
    test_rx_basic();
    test_rx_full_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
